// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and stream-format constants for the program loader
package loader_pkg;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } load_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - shifts payload bytes into little-endian words and keeps the running XOR checksum
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic [31:0] word_o,
  output logic        word_done_o,
  output logic [7:0]  checksum_o
);

  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [7:0]            csum_q, csum_d;

  // The fourth byte is combined combinationally so the parent can register the full word on the same edge.
  assign word_o      = {byte_data_i, shift_q};
  assign word_done_o = byte_valid_i && (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign checksum_o  = csum_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      shift_d    = '0;
      csum_d     = '0;
    end else if (byte_valid_i) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      shift_d    = {byte_data_i, shift_q[23:8]};
      csum_d     = csum_q ^ byte_data_i;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader that writes a checksum-verified byte stream into instruction memory
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  load_state_e       state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [ADDR_W:0]   word_idx_inc;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;

  logic              xfer;
  logic              asm_valid;
  logic              asm_clear;
  logic [31:0]       asm_word;
  logic              asm_word_done;
  logic [7:0]        asm_csum;
  logic [15:0]       n_full;

  assign rx_ready     = (state_q == HDR0) || (state_q == HDR1) ||
                        (state_q == DATA) || (state_q == CSUM);
  assign xfer         = rx_valid && rx_ready;
  assign asm_valid    = xfer && (state_q == DATA);
  assign word_idx_inc = word_idx_q + 1'b1;
  assign n_full       = {rx_data, n_q[7:0]};

  assign cpu_reset  = (state_q != DONE);
  assign load_done  = (state_q == DONE);
  assign load_error = (state_q == ERR);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;

  word_assembler u_word_assembler (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_data_i  (rx_data),
    .word_o       (asm_word),
    .word_done_o  (asm_word_done),
    .checksum_o   (asm_csum)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_idx_d   = word_idx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    asm_clear    = 1'b0;

    case (state_q)
      HDR0: begin
        if (xfer) begin
          n_d[7:0] = rx_data;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          n_d[15:8] = rx_data;
          if (int'(n_full) > MAX_WORDS) begin
            state_d = ERR;
          end else if (n_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (asm_word_done) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_idx_q[ADDR_W-1:0];
          imem_wdata_d = asm_word;
          word_idx_d   = word_idx_inc;
          if (32'(word_idx_inc) == 32'(n_q)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = (rx_data == asm_csum) ? DONE : ERR;
        end
      end
      DONE, ERR: begin
        // Restart wipes all per-image progress; the write port keeps its last values.
        if (start) begin
          state_d    = HDR0;
          n_d        = '0;
          word_idx_d = '0;
          asm_clear  = 1'b1;
        end
      end
      default: begin
        state_d = HDR0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= HDR0;
      n_q          <= '0;
      word_idx_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

endmodule
